// File: rtl/esn_mem_pkg.sv
// rtl/esn_mem_pkg.sv - shared defaults and FSM state encoding for the capture block
package esn_mem_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 9;
  localparam int DEF_DEPTH  = 64;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_FLUSH   = 2'd2
  } state_t;

endpackage

// File: rtl/mem_wr_ctr.sv
// rtl/mem_wr_ctr.sv - capture write address and sample counter
module mem_wr_ctr #(
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              sclr,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W:0]   count,
  output logic              full
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   LAST_CNT  = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0]   MAX_CNT   = (ADDR_W + 1)'(DEPTH);

  // full flags the increment that fills the buffer, so the FSM can leave on the same edge
  assign full = inc && (count == LAST_CNT);

  always_ff @(posedge clk) begin
    if (sclr || clr) begin
      addr  <= '0;
      count <= '0;
    end else if (inc) begin
      addr <= (addr == LAST_ADDR) ? '0 : addr + ADDR_W'(1);
      if (count != MAX_CNT)
        count <= count + (ADDR_W + 1)'(1);
    end
  end

endmodule

// File: rtl/mem_capture.sv
// rtl/mem_capture.sv - streams samples into a single-port RAM; MEM_CAPTURE_WRAP_EN selects circular capture
module mem_capture
  import esn_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              sclr,
  input  logic              ce,
  input  logic              start,
  input  logic              stop,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count
);

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic              full;
  logic              accept;
  logic              launch;

  assign in_ready = (state == ST_CAPTURE) & ce;
  // stop outranks a simultaneous sample: the sample is dropped
  assign accept   = in_ready & in_valid & ~stop;
  assign launch   = (state == ST_IDLE) & ce & start;
  assign busy     = (state != ST_IDLE);

  mem_wr_ctr #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ctr (
    .clk   (clk),
    .sclr  (sclr),
    .clr   (launch),
    .inc   (accept),
    .addr  (addr),
    .count (count),
    .full  (full)
  );

  // mem_wren and done are event strobes: each fires once per event even if ce then drops
  always_ff @(posedge clk) begin
    if (sclr) begin
      state    <= ST_IDLE;
      mem_addr <= '0;
      mem_data <= '0;
      mem_wren <= 1'b0;
      done     <= 1'b0;
    end else begin
      mem_wren <= accept;
      done     <= 1'b0;
      if (accept) begin
        mem_addr <= addr;
        mem_data <= in_data;
      end
      if (ce) begin
        case (state)
          ST_IDLE:
            if (start) state <= ST_CAPTURE;
          ST_CAPTURE:
            if (stop) state <= ST_FLUSH;
`ifndef MEM_CAPTURE_WRAP_EN
            else if (full) state <= ST_FLUSH;
`endif
          ST_FLUSH: begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef MEM_CAPTURE_WRAP_EN
  logic unused_full;
  assign unused_full = full;
`endif

endmodule

// File: tb/tb_mem_capture.sv
// tb/tb_mem_capture.sv - scoreboard bench for mem_capture against a capture-session model
module tb_mem_capture;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 9;
  localparam int DEPTH  = 64;
`ifdef MEM_CAPTURE_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              sclr, ce, start, stop, in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready, mem_wren, busy, done;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic [ADDR_W:0]   count;

  mem_capture #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .sclr(sclr), .ce(ce), .start(start), .stop(stop),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren),
    .busy(busy), .done(done), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; int addr; logic [DATA_W-1:0] data; } wr_t;
  typedef struct { int cyc; int cnt; } dn_t;
  wr_t wq[$];
  dn_t dq[$];

  int cyc = 0, n_cmp = 0, n_bad = 0;
  // session model: capturing, closing (one edge before done), samples taken, next address
  bit m_cap = 0, m_close = 0, m_zero = 0, run = 0;
  int m_n = 0, m_addr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_edge();
    cyc++;
    m_zero = 0;
    if (sclr) begin
      m_cap = 0; m_close = 0; m_n = 0; m_addr = 0; m_zero = 1;
    end else if (ce) begin
      if (m_close) begin
        m_close = 0;
        dq.push_back('{cyc, m_n});
      end else if (m_cap) begin
        if (stop) begin
          m_cap = 0; m_close = 1;
        end else if (in_valid) begin
          wq.push_back('{cyc, m_addr, in_data});
          m_addr = (m_addr + 1) % DEPTH;
          if (m_n < DEPTH) m_n++;
          if (!WRAP && m_n == DEPTH) begin m_cap = 0; m_close = 1; end
        end
      end else if (start) begin
        m_cap = 1; m_n = 0; m_addr = 0;
      end
    end
  endtask

  task automatic step(input bit st, input bit sp, input bit v, input bit c, input bit s);
    start = st; stop = sp; in_valid = v; ce = c; sclr = s;
    in_data = DATA_W'($urandom);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  always @(negedge clk) begin
    if (run) begin
      bit ew, ed;
      chk("count", 32'(count), 32'(m_n));
      chk("busy", 32'(busy), 32'(m_cap | m_close));
      chk("in_ready", 32'(in_ready), 32'(m_cap & ce));
      if (m_zero) begin
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_data", 32'(mem_data), 32'd0);
      end
      ew = (wq.size() > 0) && (wq[0].cyc == cyc);
      chk("mem_wren", 32'(mem_wren), 32'(ew));
      if (ew) begin
        wr_t e;
        e = wq.pop_front();
        if (mem_wren) begin
          chk("mem_addr", 32'(mem_addr), 32'(e.addr));
          chk("mem_data", 32'(mem_data), 32'(e.data));
        end
      end
      ed = (dq.size() > 0) && (dq[0].cyc == cyc);
      chk("done", 32'(done), 32'(ed));
      if (ed) begin
        dn_t d;
        d = dq.pop_front();
        if (done) chk("done_count", 32'(count), 32'(d.cnt));
      end
    end
  end

  initial begin
    step(0, 0, 0, 1, 1);
    run = 1;
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 0);
    // full capture with valid held high
    step(1, 0, 0, 1, 0);
    repeat (66) step(0, 0, 1, 1, 0);
    repeat (3) step(0, 0, 0, 1, 0);
    // valid toggling, ce low every fourth cycle
    step(1, 0, 0, 1, 0);
    for (int i = 0; i < 150; i++) step(0, 0, (i % 2) == 0, (i % 4) != 3, 0);
    repeat (3) step(0, 0, 0, 1, 0);
    // abort after ten samples, with a sample offered alongside stop
    step(1, 0, 0, 1, 0);
    repeat (10) step(0, 0, 1, 1, 0);
    step(0, 1, 1, 1, 0);
    repeat (3) step(0, 0, 0, 1, 0);
    // reset mid-capture
    step(1, 0, 0, 1, 0);
    repeat (5) step(0, 0, 1, 1, 0);
    step(0, 0, 1, 1, 1);
    repeat (3) step(0, 0, 0, 1, 0);
    // stop in idle, then start during capture
    repeat (3) step(0, 1, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    repeat (4) step(0, 0, 1, 1, 0);
    step(1, 0, 1, 1, 0);
    repeat (3) step(0, 0, 1, 1, 0);
    step(0, 1, 0, 1, 0);
    repeat (3) step(0, 0, 0, 1, 0);
    // simultaneous start and stop in idle
    step(1, 1, 1, 1, 0);
    repeat (3) step(0, 0, 1, 1, 0);
    step(0, 1, 0, 1, 0);
    repeat (3) step(0, 0, 0, 1, 0);
    // seventy samples then stop
    step(1, 0, 0, 1, 0);
    repeat (70) step(0, 0, 1, 1, 0);
    step(0, 1, 0, 1, 0);
    repeat (3) step(0, 0, 0, 1, 0);
    // random traffic
    repeat (3000)
      step($urandom_range(0, 19) == 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 2) != 0, $urandom_range(0, 4) != 0,
           $urandom_range(0, 299) == 0);
    repeat (3) step(0, 0, 0, 1, 0);
    run = 0;
    chk("writes_pending", 32'(wq.size()), 32'd0);
    chk("done_pending", 32'(dq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
